float_triple_packer: RTL
========================

Name: float_triple_packer

Overview:
- Upstream feeder for the three-float sorter. Accepts a serial stream of FLEN-bit floating-point numbers over a valid/ready handshake and groups them into triples.
- Presents each triple as an unsorted [0:2][FLEN-1:0] vector with its own valid/ready handshake, directly consumable by the sort stage.
- A partial final group (stream ended by in_last) is padded with +infinity so the padding sorts to the top.

Parameters:
- FLEN, from config-shared.vh (normally 64): float width; not overridable per instance.
- PAD_VALUE, {1'b0, all-ones exponent, zero mantissa}: +infinity for FLEN; used for padding slots.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input float valid.
- in_ready  output  1  block can accept an input float.
- in_data  input  FLEN  input float.
- in_last  input  1  last float of stream; closes the current group.
- out_valid  output  1  triple valid.
- out_ready  input  1  downstream accepts the triple.
- out_data  output  [0:2][FLEN-1:0]  triple in arrival order; element 0 arrived first.
- out_count  output  2  real elements in the triple (1..3); the rest are PAD_VALUE.
- out_last  output  1  triple closed by in_last.
- out_err  output  1  triple contains a NaN; see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert in the system): fill state S0, out_valid=0, out_data=0, out_count=0, out_last=0, out_err=0. in_ready=1 after reset.
- Input beat: in_valid && in_ready. Output beat: out_valid && out_ready.
- Fill FSM: S0 (0 held), S1 (slot0 held), S2 (slots 0,1 held).
  - Beat in S0, !in_last: slot0<=in_data, go to S1.
  - Beat in S1, !in_last: slot1<=in_data, go to S2.
  - Beat in S2, any in_last: emit {slot0, slot1, in_data}, count=3, go to S0.
  - Beat in S0 with in_last: emit {in, PAD, PAD}, count=1, go to S0.
  - Beat in S1 with in_last: emit {slot0, in, PAD}, count=2, go to S0.
- Emit means: load the output register next edge, out_valid<=1, out_last<=in_last.
- Output register is separate from the slots. While a triple waits, S0->S1->S2 filling continues.
- in_ready = !(emit-condition pending) || !out_valid || out_ready.
  - Equivalently, in_ready deasserts only when out_valid=1, out_ready=0, and the incoming beat would emit (state S2, or in_last asserted).
  - in_ready depends combinationally on in_last and out_ready. There is no combinational path from in_valid to in_ready.
- Simultaneous output beat and emit in the same cycle: the output register reloads and out_valid stays 1. Full throughput is one float per cycle, one triple per 3 cycles.
- Output beat without emit: out_valid<=0 next edge. out_data holds its last value.
- out_data, out_count, out_last and out_err are stable while out_valid=1 and out_ready=0.
- in_last in S0 with no pending data is a real one-element group; there is no empty-group emission.
- Reset mid-group discards slots and any pending triple.

Optional Feature:
- Macro FLOAT_PACKER_NAN_CHECK_EN.
- Defined:
  - Each slot carries a NaN flag (exponent all ones, mantissa nonzero). PAD never sets it.
  - out_err = OR of the flags of the emitted triple, registered with out_data.
  - out_err is updated only on emit and cleared on reset.
- Undefined: out_err tied to 0. No flag registers exist.

Decomposition:
- Shared package float_pack_pkg:
  - typedef float_t = logic [FLEN-1:0].
  - typedef float_triple_t = float_t [0:2].
  - constant FLOAT_POS_INF.
  - function is_nan(float_t).
  - enum fill_state_t {S0, S1, S2}.
- No sub-module is needed. The NaN detect is the package function; the fill FSM and output register stay in one module.

Test Plan:
- Stream 1.0, 2.0, 3.0, 4.0, 5.0, 6.0 (FP64) with out_ready=1 -> two triples {1,2,3} and {4,5,6}, count=3, out_valid on the cycle after each third beat, in_ready always 1.
- 7.0, 8.0(last) -> {7.0, 8.0, +inf(0x7FF0000000000000)}, count=2, out_last=1. A single 9.0(last) -> {9.0, +inf, +inf}, count=1.
- Continuous in_valid with out_ready=0 -> first triple held stable. 4th and 5th floats accepted; in_ready=0 at the 6th float. out_ready=1 for one cycle -> 6th float accepted that cycle and the second triple loads with no gap.
- Back-to-back triples with out_ready=1, in_valid=1 every cycle -> 1 triple per 3 cycles, no in_ready bubbles.
- Deassert rst_n mid-group (state S2) and with out_valid=1 -> out_valid=0 immediately (async). The next three floats form a fresh triple with no stale data.
- With FLOAT_PACKER_NAN_CHECK_EN: 1.0, 0x7FF8000000000000, 2.0 -> out_err=1; the next clean triple -> out_err=0; a padded triple containing no NaN -> out_err=0.

Source files
------------

// File: rtl/float_triple_packer_pkg.sv
// rtl/float_triple_packer_pkg.sv - shared float types, +inf constant, NaN detect and fill states
package float_pack_pkg;

  localparam int FLEN  = 64;
  localparam int EXP_W = 11;
  localparam int MAN_W = FLEN - 1 - EXP_W;

  typedef logic [FLEN-1:0] float_t;
  typedef float_t [0:2] float_triple_t;

  localparam float_t FLOAT_POS_INF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } fill_state_t;

  function automatic logic is_nan(input float_t f);
    return (f[FLEN-2 -: EXP_W] == {EXP_W{1'b1}}) && (f[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/float_triple_packer_if.sv
// rtl/float_triple_packer_if.sv - float input stream and triple output handshake bundle
interface float_triple_packer_if;
  import float_pack_pkg::*;

  logic          in_valid;
  logic          in_ready;
  float_t        in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  float_triple_t out_data;
  logic [1:0]    out_count;
  logic          out_last;
  logic          out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last, out_err
  );

endinterface

// File: rtl/float_triple_packer.sv
// rtl/float_triple_packer.sv - groups a float stream into +inf-padded triples for the sort stage
// FLOAT_PACKER_NAN_CHECK_EN adds per-slot NaN flags and a registered out_err.
module float_triple_packer
  import float_pack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  float_triple_packer_if.slave bus
);

  localparam float_t     PAD_VALUE = FLOAT_POS_INF;
  localparam logic [1:0] ST_S0     = S0;
  localparam logic [1:0] ST_S1     = S1;
  localparam logic [1:0] ST_S2     = S2;

  logic [1:0]    state_q, state_d;
  float_t        slot0_q, slot0_d;
  float_t        slot1_q, slot1_d;
  float_triple_t out_data_q, out_data_d;
  logic [1:0]    out_count_q, out_count_d;
  logic          out_last_q, out_last_d;
  logic          out_valid_q, out_valid_d;

  logic          emit_cond;
  logic          in_ready;
  logic          in_beat;
  logic          emit;
  float_triple_t emit_data;
  logic [1:0]    emit_count;

  // Stall only when this beat would emit while the output register is still owed downstream.
  always_comb begin
    emit_cond = (state_q == ST_S2) || bus.in_last;
    in_ready  = !emit_cond || !out_valid_q || bus.out_ready;
    in_beat   = bus.in_valid && in_ready;
    emit      = in_beat && emit_cond;
  end

  always_comb begin
    state_d     = state_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    emit_data   = {bus.in_data, PAD_VALUE, PAD_VALUE};
    emit_count  = 2'd1;
    case (state_q)
      ST_S1: begin
        emit_data  = {slot0_q, bus.in_data, PAD_VALUE};
        emit_count = 2'd2;
      end
      ST_S2: begin
        emit_data  = {slot0_q, slot1_q, bus.in_data};
        emit_count = 2'd3;
      end
      default: begin
        emit_data  = {bus.in_data, PAD_VALUE, PAD_VALUE};
        emit_count = 2'd1;
      end
    endcase
    if (emit) begin
      state_d     = ST_S0;
      out_data_d  = emit_data;
      out_count_d = emit_count;
      out_last_d  = bus.in_last;
      out_valid_d = 1'b1;
    end else if (in_beat) begin
      if (state_q == ST_S1) begin
        slot1_d = bus.in_data;
        state_d = ST_S2;
      end else begin
        slot0_d = bus.in_data;
        state_d = ST_S1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_S0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= 2'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FLOAT_PACKER_NAN_CHECK_EN
  logic nan0_q, nan0_d;
  logic nan1_q, nan1_d;
  logic out_err_q, out_err_d;
  logic in_nan;

  // Flags follow the slots; padding never contributes a NaN.
  always_comb begin
    in_nan    = is_nan(bus.in_data);
    nan0_d    = nan0_q;
    nan1_d    = nan1_q;
    out_err_d = out_err_q;
    if (emit) begin
      case (state_q)
        ST_S1:   out_err_d = nan0_q | in_nan;
        ST_S2:   out_err_d = nan0_q | nan1_q | in_nan;
        default: out_err_d = in_nan;
      endcase
    end else if (in_beat) begin
      if (state_q == ST_S1) nan1_d = in_nan;
      else                  nan0_d = in_nan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan0_q    <= 1'b0;
      nan1_q    <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      nan0_q    <= nan0_d;
      nan1_q    <= nan1_d;
      out_err_q <= out_err_d;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;

endmodule
